cdb_arbiter: RTL

- Shares the single result-writeback path into the reorder buffer between three producers: ALU reservation station, load buffer and store buffer.
- Each producer pushes finished results into its own small FIFO.
- A round-robin scheduler drains one entry per cycle onto a registered common data bus (CDB). The ROB and both reservation stations snoop the CDB.
- Sits between the execution units and the rob/rs/lsb listen ports. Honours the global flush (clear_all) and pause (rdy_in).

---
 rtl/cdb_arbiter_pkg.sv | 25 ++
 rtl/cdb_arbiter_if.sv | 44 ++++
 rtl/cdb_arbiter_src_fifo.sv | 57 +++++
 rtl/cdb_arbiter.sv | 113 +++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and helpers for the CDB arbiter: source IDs, default
// depths and the modulo-3 round-robin step.
package cdb_arbiter_pkg;

    localparam int REG_ID_BIT = 4;
    localparam int CDB_QDEPTH = 2;
    localparam int CDB_NSRC   = 3;

    typedef enum logic [1:0] {
        CDB_SRC_ALU = 2'd0,
        CDB_SRC_LB  = 2'd1,
        CDB_SRC_SB  = 2'd2
    } cdb_src_e;

    // (base + k) mod 3 for base, k in 0..2
    function automatic logic [1:0] src_add(input logic [1:0] base, input logic [1:0] k);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, k};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side and broadcast-side signals of the CDB arbiter.
// The arbiter uses the slave modport; producers/listeners use master.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int DEST_W = REG_ID_BIT
);
    logic              alu_valid;
    logic [DEST_W-1:0] alu_dest;
    logic [31:0]       alu_value;
    logic [31:0]       alu_jalr_pc;
    logic              alu_ready;

    logic              lb_valid;
    logic [DEST_W-1:0] lb_dest;
    logic [31:0]       lb_value;
    logic              lb_ready;

    logic              sb_valid;
    logic [DEST_W-1:0] sb_dest;
    logic              sb_ready;

    logic              cdb_valid;
    logic [1:0]        cdb_src;
    logic [DEST_W-1:0] cdb_dest;
    logic [31:0]       cdb_value;
    logic [31:0]       cdb_jalr_pc;

    modport master (
        output alu_valid, alu_dest, alu_value, alu_jalr_pc,
        output lb_valid, lb_dest, lb_value,
        output sb_valid, sb_dest,
        input  alu_ready, lb_ready, sb_ready,
        input  cdb_valid, cdb_src, cdb_dest, cdb_value, cdb_jalr_pc
    );

    modport slave (
        input  alu_valid, alu_dest, alu_value, alu_jalr_pc,
        input  lb_valid, lb_dest, lb_value,
        input  sb_valid, sb_dest,
        output alu_ready, lb_ready, sb_ready,
        output cdb_valid, cdb_src, cdb_dest, cdb_value, cdb_jalr_pc
    );
endinterface

// File: rtl/cdb_arbiter_src_fifo.sv
// Small per-producer result FIFO. hold freezes everything; flush empties it
// and wins over push/pop. Head entry is presented combinationally on dout.
module cdb_arbiter_src_fifo #(
    parameter int WIDTH  = 68,
    parameter int QDEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic             hold,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int PW = $clog2(QDEPTH);

    logic [WIDTH-1:0] mem_q [QDEPTH];
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [PW:0]      count_q;

    assign dout  = mem_q[head_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == (PW+1)'(QDEPTH));

    always_ff @(posedge clk) begin
        if (push && !hold && !flush) begin
            mem_q[tail_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (!hold) begin
            if (flush) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (push) tail_q <= tail_q + 1'b1;
                if (pop)  head_q <= head_q + 1'b1;
                case ({push, pop})
                    2'b10:   count_q <= count_q + (PW+1)'(1);
                    2'b01:   count_q <= count_q - (PW+1)'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter draining three producer FIFOs (ALU, LB, SB) onto a
// single registered common data bus, one broadcast per cycle.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int QDEPTH = CDB_QDEPTH,
    parameter int DEST_W = REG_ID_BIT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_all,
    cdb_arbiter_if.slave bus
);
    localparam int W = DEST_W + 64;

    logic [W-1:0]        fifo_din  [CDB_NSRC];
    logic [W-1:0]        fifo_dout [CDB_NSRC];
    logic [CDB_NSRC-1:0] fifo_push;
    logic [CDB_NSRC-1:0] fifo_pop;
    logic [CDB_NSRC-1:0] fifo_empty;
    logic [CDB_NSRC-1:0] fifo_full;

    logic              grant;
    logic [1:0]        winner;
    logic [W-1:0]      head_sel;

    logic              cdb_valid_q;
    logic [1:0]        cdb_src_q;
    logic [DEST_W-1:0] cdb_dest_q;
    logic [31:0]       cdb_value_q;
    logic [31:0]       cdb_jalr_pc_q;
    logic [1:0]        rr_q;

    // Entry layout is {dest, value, jalr_pc}; LB/SB zero the fields they lack.
    assign fifo_din[0] = {bus.alu_dest, bus.alu_value, bus.alu_jalr_pc};
    assign fifo_din[1] = {bus.lb_dest, bus.lb_value, 32'd0};
    assign fifo_din[2] = {bus.sb_dest, 64'd0};
    assign fifo_push   = {bus.sb_valid, bus.lb_valid, bus.alu_valid} & ~fifo_full;

    assign bus.alu_ready = ~fifo_full[0];
    assign bus.lb_ready  = ~fifo_full[1];
    assign bus.sb_ready  = ~fifo_full[2];

    generate
        for (genvar gi = 0; gi < CDB_NSRC; gi++) begin : g_src
            assign fifo_pop[gi] = grant && (winner == 2'(gi));

            cdb_arbiter_src_fifo #(
                .WIDTH  (W),
                .QDEPTH (QDEPTH)
            ) u_fifo (
                .clk   (clk_in),
                .rst   (rst_in),
                .push  (fifo_push[gi]),
                .pop   (fifo_pop[gi]),
                .flush (clear_all),
                .hold  (!rdy_in),
                .din   (fifo_din[gi]),
                .dout  (fifo_dout[gi]),
                .empty (fifo_empty[gi]),
                .full  (fifo_full[gi])
            );
        end
    endgenerate

    always_comb begin
        logic [1:0] idx;
        grant  = 1'b0;
        winner = CDB_SRC_ALU;
        idx    = rr_q;
        for (int k = 0; k < CDB_NSRC; k++) begin
            idx = src_add(rr_q, 2'(k));
            if (!grant && !fifo_empty[idx]) begin
                grant  = 1'b1;
                winner = idx;
            end
        end
    end

    assign head_sel = fifo_dout[winner];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cdb_valid_q   <= 1'b0;
            cdb_src_q     <= CDB_SRC_ALU;
            cdb_dest_q    <= '0;
            cdb_value_q   <= '0;
            cdb_jalr_pc_q <= '0;
            rr_q          <= CDB_SRC_ALU;
        end else if (rdy_in) begin
            if (clear_all) begin
                cdb_valid_q <= 1'b0;
                rr_q        <= CDB_SRC_ALU;
            end else if (grant) begin
                cdb_valid_q <= 1'b1;
                cdb_src_q   <= winner;
                {cdb_dest_q, cdb_value_q, cdb_jalr_pc_q} <= head_sel;
                rr_q        <= src_add(winner, 2'd1);
            end else begin
                // Idle: data outputs keep the last broadcast
                cdb_valid_q <= 1'b0;
            end
        end
    end

    assign bus.cdb_valid   = cdb_valid_q;
    assign bus.cdb_src     = cdb_src_q;
    assign bus.cdb_dest    = cdb_dest_q;
    assign bus.cdb_value   = cdb_value_q;
    assign bus.cdb_jalr_pc = cdb_jalr_pc_q;

endmodule
